dmem_sram_bridge: RTL

Memory-side responder for the CPU data-memory port. It accepts the M-stage load/store request and converts it into an SRAM-like split-handshake bus transaction (address phase, then data phase). It generates `stallreq_from_mem` to freeze the pipeline until the transaction completes, and holds load data stable until the M stage advances.

---
 rtl/dmem_sram_bridge.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge: responder for the CPU data-memory port. Turns an M-stage
// load/store into a split address/data-phase SRAM-like bus transaction, stalls
// the pipeline until it completes and holds load data until M advances.
// Optional feature: define DMEM_POSTED_WRITE_EN to let stores retire after
// their address phase, with the data phase tracked by a pending flag.
module dmem_sram_bridge #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_en,
  input  logic [3:0]      mem_wen,
  input  logic [1:0]      mem_size,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_wdata,
  input  logic            mem_flush,
  input  logic            cpu_stall,
  output logic [DW-1:0]   mem_rdata,
  output logic            stallreq_from_mem,
  output logic            data_req,
  output logic            data_wr,
  output logic [1:0]      data_size,
  output logic [AW-1:0]   data_addr,
  output logic [DW-1:0]   data_wdata,
  input  logic            data_addr_ok,
  input  logic            data_data_ok,
  input  logic [DW-1:0]   data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, nextState;
  logic   isWrite;
  logic   busReq;
  logic   loadData;
  logic   pendingBusy;   // a posted write still owns the data phase this cycle
  logic   dataOkFree;    // data_data_ok not consumed by a posted write
  logic   postStore;     // an accepted store may retire without its data phase

  assign isWrite = |mem_wen;

`ifdef DMEM_POSTED_WRITE_EN
  logic wrPending;
  logic setPending;

  assign pendingBusy = wrPending & ~data_data_ok;
  assign dataOkFree  = data_data_ok & ~wrPending;
  assign postStore   = isWrite;
  assign setPending  = busReq & data_addr_ok & isWrite & ~dataOkFree;

  // Track the outstanding data phase of a store that already retired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              wrPending <= 1'b0;
    else if (setPending)   wrPending <= 1'b1;
    else if (data_data_ok) wrPending <= 1'b0;
  end
`else
  assign pendingBusy = 1'b0;
  assign dataOkFree  = data_data_ok;
  assign postStore   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic, bus request and load-capture decision.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    nextState = state;
    busReq    = 1'b0;
    loadData  = 1'b0;
    unique case (state)
      IDLE, REQ: begin
        // A flushed or withdrawn request never reaches the bus.
        if (mem_en && !mem_flush && !pendingBusy) begin
          busReq = 1'b1;
          if (data_addr_ok) begin
            if (dataOkFree) begin
              nextState = DONE;
              loadData  = ~isWrite;
            end else if (postStore) begin
              nextState = DONE;
            end else begin
              nextState = WAIT;
            end
          end else begin
            nextState = REQ;
          end
        end else begin
          nextState = IDLE;
        end
      end
      WAIT: begin
        // Flush is ignored: the accepted transaction must finish.
        if (data_data_ok) begin
          nextState = DONE;
          loadData  = ~isWrite;
        end
      end
      DONE: begin
        if (!cpu_stall) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Load data holding register; only read data phases update it.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this is a single datapath register, so it is reset to give a
    // defined value; a RAM array would not be.
    if (!rst)          mem_rdata <= '0;
    else if (loadData) mem_rdata <= data_rdata;
  end

  // Bus fields follow the held M-stage inputs; reset forces request/stall low.
  assign data_req          = rst & busReq;
  assign data_wr           = data_req & isWrite;
  assign data_size         = mem_size;
  assign data_addr         = mem_addr;
  assign data_wdata        = mem_wdata;
  assign stallreq_from_mem = rst & mem_en & (state != DONE) &
                             ~(mem_flush & ((state == IDLE) | (state == REQ)));

endmodule
